sync_edge_event: RTL and testbench



---
 rtl/sync_pkg.sv | 15 +
 rtl/debounce_filter.sv | 37 +++
 rtl/sync_edge_event.sv | 91 +++++++++
 tb/tb_sync_edge_event.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared definitions for the synchronized-edge event logic: edge-select
// encodings and a helper that decides whether a level change is selected.
package sync_pkg;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // new_lvl is the level after the change: 1 means a rising edge.
  function automatic logic edge_selected(input logic [1:0] sel, input logic new_lvl);
    return new_lvl ? sel[0] : sel[1];
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Debounce filter: lvl follows in only after in has differed from lvl for
// DB_CYCLES consecutive cycles. chg flags the cycle whose clock edge will
// flip lvl, so the parent can register its edge pulse on that same edge.
module debounce_filter #(
  parameter int   DB_CYCLES = 16,
  parameter logic RST_LVL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic lvl,
  output logic chg
);

  localparam int             CW   = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign chg = (in != lvl) && (cnt == LAST);

  // Count consecutive mismatching cycles; any matching cycle restarts qualification.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl <= RST_LVL;
      cnt <= '0;
    end else if (in == lvl) begin
      cnt <= '0;
    end else if (chg) begin
      lvl <= in;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sync_edge_event.sv
// sync_edge_event: turns an already-synchronized level into counted,
// handshaked events. Optional debounce filter selected by the macro
// SYNC_EDGE_DEBOUNCE_EN; without it the filter is a single register.
//
// Handshake: evt_valid is high whenever evt_cnt is non-zero. One event is
// consumed on every clock edge where evt_valid && evt_ready; evt_ready while
// evt_valid is low has no effect. A new edge and a consume on the same edge
// cancel, which also keeps a full counter from overflowing.
module sync_edge_event
  import sync_pkg::*;
#(
  parameter int         CNT_W     = 4,
  parameter int         DB_CYCLES = 16,
  parameter logic [1:0] EDGE_SEL  = 2'b01,
  parameter logic       RST_LVL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_sync,
  output logic             lvl,
  output logic             edge_pulse,
  output logic             edge_rise,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic lvl_chg;
  logic inc;
  logic dec;

`ifdef SYNC_EDGE_DEBOUNCE_EN
  debounce_filter #(
    .DB_CYCLES (DB_CYCLES),
    .RST_LVL   (RST_LVL)
  ) u_filter (
    .clk (clk),
    .rst (rst),
    .in  (in_sync),
    .lvl (lvl),
    .chg (lvl_chg)
  );
`else
  logic unused_db;
  assign unused_db = ^DB_CYCLES;
  assign lvl_chg   = (in_sync != lvl);

  // Plain filter: lvl simply follows in_sync one cycle later.
  always_ff @(posedge clk) begin
    if (rst) lvl <= RST_LVL;
    else     lvl <= in_sync;
  end
`endif

  // After a change the new level is the inverse of the current one.
  assign inc       = lvl_chg && edge_selected(EDGE_SEL, ~lvl);
  assign evt_valid = (evt_cnt != '0);
  assign dec       = evt_valid && evt_ready;

  // Edge pulse and direction registered on the edge that updates lvl.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_pulse <= 1'b0;
      edge_rise  <= 1'b0;
    end else begin
      edge_pulse <= inc;
      if (inc) edge_rise <= ~lvl;
    end
  end

  // Pending-event counter with saturation and sticky overflow (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      if (inc && !dec) begin
        if (evt_cnt == CNT_MAX) ovf <= 1'b1;
        else                    evt_cnt <= evt_cnt + 1'b1;
      end else if (!inc && dec) begin
        evt_cnt <= evt_cnt - 1'b1;
      end
      if (ovf_clr && !(inc && !dec && evt_cnt == CNT_MAX)) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_edge_event.sv
// Testbench for sync_edge_event. Two instances share the stimulus:
// A (CNT_W=2, both edges) and B (CNT_W=4, rising only). A cycle model
// pushes expected outputs per driven cycle; they are popped after the edge.
module tb_sync_edge_event;

`ifdef SYNC_EDGE_DEBOUNCE_EN
  localparam int MDB = 16;
`else
  localparam int MDB = 1;
`endif

  logic clk = 1'b0;
  logic rst, in_sync, evt_ready, ovf_clr;

  logic       a_lvl, a_pulse, a_rise, a_valid, a_ovf;
  logic [1:0] a_cnt;
  logic       b_lvl, b_pulse, b_rise, b_valid, b_ovf;
  logic [3:0] b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [17:0] exp_q[$];

  // model state, index 0 = A, 1 = B
  logic       m_lvl[2];
  int         m_run[2];
  logic       m_pulse[2];
  logic       m_rise[2];
  int         m_cnt[2];
  logic       m_ovf[2];
  int         m_max[2];
  logic [1:0] m_sel[2];

  // clock / reset block
  always #5 clk = ~clk;

  sync_edge_event #(.CNT_W(2), .DB_CYCLES(16), .EDGE_SEL(2'b11), .RST_LVL(1'b0)) u_a (
    .clk(clk), .rst(rst), .in_sync(in_sync), .lvl(a_lvl), .edge_pulse(a_pulse),
    .edge_rise(a_rise), .evt_valid(a_valid), .evt_ready(evt_ready), .evt_cnt(a_cnt),
    .ovf(a_ovf), .ovf_clr(ovf_clr)
  );

  sync_edge_event #(.CNT_W(4), .DB_CYCLES(16), .EDGE_SEL(2'b01), .RST_LVL(1'b0)) u_b (
    .clk(clk), .rst(rst), .in_sync(in_sync), .lvl(b_lvl), .edge_pulse(b_pulse),
    .edge_rise(b_rise), .evt_valid(b_valid), .evt_ready(evt_ready), .evt_cnt(b_cnt),
    .ovf(b_ovf), .ovf_clr(ovf_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input logic r, input logic d, input logic rdy,
                            input logic clr);
    logic chg, newl, hit, dec, ovf_set;
    if (r) begin
      m_lvl[i] = 1'b0; m_run[i] = 0; m_pulse[i] = 1'b0; m_rise[i] = 1'b0;
      m_cnt[i] = 0;    m_ovf[i] = 1'b0;
    end else begin
      chg = 1'b0;
      if (d != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] >= MDB) begin
          chg = 1'b1;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      newl    = chg ? d : m_lvl[i];
      hit     = chg && (newl ? m_sel[i][0] : m_sel[i][1]);
      dec     = (m_cnt[i] != 0) && rdy;
      ovf_set = hit && !dec && (m_cnt[i] == m_max[i]);
      m_pulse[i] = hit;
      if (hit) m_rise[i] = newl;
      if (hit && !dec && m_cnt[i] < m_max[i]) m_cnt[i]++;
      else if (!hit && dec)                   m_cnt[i]--;
      m_ovf[i] = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf[i]);
      m_lvl[i] = newl;
    end
  endtask

  function automatic logic [8:0] pack(input int i);
    return {m_lvl[i], m_pulse[i], m_rise[i], (m_cnt[i] != 0), 4'(m_cnt[i]), m_ovf[i]};
  endfunction

  task automatic compare_inst(input string nm, input logic [8:0] got, input logic [8:0] exp);
    check({nm, ".lvl"},   32'(got[8]),   32'(exp[8]));
    check({nm, ".pulse"}, 32'(got[7]),   32'(exp[7]));
    check({nm, ".rise"},  32'(got[6]),   32'(exp[6]));
    check({nm, ".valid"}, 32'(got[5]),   32'(exp[5]));
    check({nm, ".cnt"},   32'(got[4:1]), 32'(exp[4:1]));
    check({nm, ".ovf"},   32'(got[0]),   32'(exp[0]));
  endtask

  // driver: apply one cycle of inputs, predict, then score after the edge
  task automatic step(input logic r, input logic d, input logic rdy, input logic clr);
    logic [17:0] e;
    rst = r; in_sync = d; evt_ready = rdy; ovf_clr = clr;
    model_step(0, r, d, rdy, clr);
    model_step(1, r, d, rdy, clr);
    exp_q.push_back({pack(0), pack(1)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    compare_inst("A", {a_lvl, a_pulse, a_rise, a_valid, 2'b00, a_cnt, a_ovf}, e[17:9]);
    compare_inst("B", {b_lvl, b_pulse, b_rise, b_valid, b_cnt, b_ovf}, e[8:0]);
  endtask

  // hold a level until it has just been accepted (MDB cycles), then extra cycles
  task automatic hold(input logic d, input int extra, input logic rdy);
    for (int k = 0; k < MDB + extra; k++) step(1'b0, d, rdy, 1'b0);
  endtask

  initial begin
    logic d;
    m_max[0] = 3;  m_sel[0] = 2'b11;
    m_max[1] = 15; m_sel[1] = 2'b01;

    // reset
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst.b_cnt", 32'(b_cnt), 0);
    check("rst.b_valid", 32'(b_valid), 0);

    // rising edge held: event appears exactly after MDB cycles
    for (int k = 0; k < MDB - 1; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("rise.pre_lvl", 32'(b_lvl), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("rise.lvl", 32'(b_lvl), 1);
    check("rise.pulse", 32'(b_pulse), 1);
    check("rise.edge_rise", 32'(b_rise), 1);
    check("rise.cnt", 32'(b_cnt), 1);
    check("rise.valid", 32'(b_valid), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("rise.pulse_one_cycle", 32'(b_pulse), 0);

    // glitch shorter than the filter window
    for (int k = 0; k < MDB - 1; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 2, 1'b0);
    check("glitch.cnt", 32'(b_cnt), 1);

    // two more rising edges queued on B; A saturates on the way
    for (int k = 0; k < 2; k++) begin
      hold(1'b0, 1, 1'b0);
      hold(1'b1, 1, 1'b0);
    end
    check("queue.b_cnt", 32'(b_cnt), 3);
    check("queue.a_ovf", 32'(a_ovf), 1);

    // drain with ready held high
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("drain.cnt2", 32'(b_cnt), 2);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("drain.cnt1", 32'(b_cnt), 1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("drain.cnt0", 32'(b_cnt), 0);
    check("drain.valid0", 32'(b_valid), 0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("drain.no_underflow", 32'(b_cnt), 0);

    // clear sticky overflow
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("clr.a_ovf", 32'(a_ovf), 0);

    // saturate A with four edges and no consumer
    hold(1'b0, 1, 1'b0);
    hold(1'b1, 1, 1'b0);
    hold(1'b0, 1, 1'b0);
    hold(1'b1, 1, 1'b0);
    check("sat.a_cnt", 32'(a_cnt), 3);
    check("sat.a_ovf", 32'(a_ovf), 1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("sat.clr", 32'(a_ovf), 0);

    // event and ready together while full
    for (int k = 0; k < MDB - 1; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("full_both.pulse", 32'(a_pulse), 1);
    check("full_both.cnt", 32'(a_cnt), 3);
    check("full_both.ovf", 32'(a_ovf), 0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b0);

    // toggle every two cycles, reset in the middle
    d = 1'b0;
    for (int t = 0; t < 12; t++) begin
      d = ~d;
      step(1'b0, d, 1'b0, 1'b0);
      step(1'b0, d, 1'b0, 1'b0);
    end
    step(1'b1, d, 1'b0, 1'b0);
    check("midrst.a_lvl", 32'(a_lvl), 0);
    check("midrst.a_pulse", 32'(a_pulse), 0);
    check("midrst.a_rise", 32'(a_rise), 0);
    check("midrst.a_cnt", 32'(a_cnt), 0);
    check("midrst.a_ovf", 32'(a_ovf), 0);
    for (int t = 0; t < 8; t++) begin
      d = ~d;
      step(1'b0, d, 1'b1, 1'b0);
      step(1'b0, d, 1'b1, 1'b0);
    end

    // random stimulus, random consumer, occasional clear and reset
    for (int r = 0; r < 150; r++) begin
      int len;
      d   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * MDB);
      for (int k = 0; k < len; k++)
        step(($urandom_range(0, 199) == 0), d, 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
